z_count_addr_l9: RTL and testbench
==================================

# z_count_addr_l9

Layer-9 channel (z) loop counter and input-feature-map read-address generator. Sits directly upstream of the layer-9 row counter (`y_count_L9`). It issues one read request per channel step over a valid/ready handshake and emits the `z_zero` wrap pulse that advances `y`. It consumes `y`, `y_zero`, `u`, `temp_counter` and `temp_zero` so that its pacing stays lock-step with the row loop.

## Interface
- `Z_MAX`, 8: channel steps per pixel; must be even and ≥ 2.
- `ROW_STRIDE`, 16: address words per row.
- `BASE`, 0: feature-map base address.
- `ADDR_W`, 12: read-address width.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a layer pass; ignored unless IDLE.
- `u`  in  3  mode:
  - 0: pause.
  - 1: stride-2, z += 2.
  - other: stride-1.
- `temp_counter`  in  1  with `!temp_zero`, requests a hold.
- `temp_zero`  in  1  temp-loop wrap.
- `y`  in  4  current row from the row counter.
- `y_zero`  in  1  row-counter wrap.
- `rd_ready`  in  1  memory accepts the request.
- `rd_valid`  out  1  request offered.
- `rd_addr`  out  ADDR_W  request address.
- `z`  out  $clog2(Z_MAX)  current channel step.
- `z_zero`  out  1  channel-loop wrap pulse.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle end-of-pass pulse.

## Operation
- FSM states: IDLE, RUN, HOLD, DONE.
- IDLE → RUN on `start`.
- RUN → HOLD when `pause` and no offer is pending.
  - `pause` = (`temp_counter && !temp_zero`) || `u==0`.
  - "No offer pending" means `rd_valid` is low, or `fire` happens this cycle.
- HOLD → RUN when `pause` deasserts.
- RUN → DONE when `z_zero && y_zero`.
- DONE → IDLE unconditionally.
- `fire` = `rd_valid && rd_ready`. The z counter advances only on `fire`.
- Step size: +2 when `u==1`, else +1.
- Wrap threshold is `Z_MAX-2` for u==1 and `Z_MAX-1` otherwise. On `fire` at or above the threshold, z returns to 0.
- `z_zero` = `fire && state==RUN && z >= threshold`. It is combinational so the row counter samples it on the same edge.
- Address rule: `rd_addr` = `BASE + y*ROW_STRIDE + z`, computed combinationally from the registered `z` and the input `y`.
  - Computed at full width, then truncated modulo 2^ADDR_W.
- Handshake rules:
  - `rd_valid` is registered. It is high in RUN, except in the cycle after a `fire` that caused the transition to HOLD or DONE.
  - Once raised, `rd_valid` stays high, with `rd_addr` stable, until `fire`.
  - `y` must not change while an offer is pending; the row counter only moves on `z_zero`, which guarantees this.
- `done`: high exactly in the DONE state; z is cleared to 0 there.
- `start` while `busy` is ignored.
- Simultaneous events:
  - `fire` and `pause` in the same cycle: the step completes, then HOLD.
  - `z_zero && y_zero` in the same cycle as `pause`: DONE takes priority.
- `u` changing while in RUN takes effect on the next `fire`. If z is odd when u becomes 1, the wrap still triggers at ≥ `Z_MAX-2`.

## Timing
- Reset values: state IDLE, `z`=0, `rd_valid`=0, `busy`=0, `done`=0, `z_zero`=0. `rd_addr` = `BASE + y*ROW_STRIDE` truncated.
- Reset asserted mid-pass: all state clears immediately and asynchronously, and any pending offer is dropped. Release requires a fresh `start`.
- `start` at cycle 0 → `busy`=1 and `rd_valid`=1 from cycle 1.
- Throughput is one request per cycle with `rd_ready` held high.
- A full pass in stride-1 mode with no stalls is Z_MAX × (rows up to `y_zero`) requests. `done` follows the final `fire` by one cycle.
- HOLD exit: `rd_valid` reasserts one cycle after `pause` clears.

## Configuration
- `Z_COUNT_L9_PERF_EN`, when defined:
  - Adds output `stall_cnt` [15:0].
  - It counts cycles with `rd_valid && !rd_ready`, saturating at 16'hFFFF.
  - It clears on `rst` and on `start`.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

## Structure
- Shared package `l9_pkg` holds:
  - the FSM state enum (IDLE/RUN/HOLD/DONE);
  - the default `Z_MAX` and `ROW_STRIDE` constants;
  - the mode encoding constants for `u` (PAUSE=0, STRIDE2=1).
- One sub-module: `l9_addr_calc`, a purely combinational `BASE + y*ROW_STRIDE + z` with truncation, reusable by other layer-9 address generators.

## Test plan
- Reset, then `start`, u=2, `rd_ready`=1:
  - `rd_valid` rises at cycle 1.
  - `rd_addr` steps 0..7 with y=0.
  - `z_zero` pulses on the 8th `fire`.
  - z returns to 0.
- u=1, `Z_MAX`=8: z sequence 0,2,4,6; `z_zero` on the `fire` at z=6; addresses `y*16+{0,2,4,6}`.
- `rd_ready` low for 5 cycles with an offer pending: `rd_valid` and `rd_addr` hold, z stays constant, and with the PERF macro `stall_cnt`=5.
- `temp_counter`=1 and `temp_zero`=0 mid-row:
  - the pending request completes, then HOLD;
  - `rd_valid`=0 and z is frozen;
  - after release, `rd_valid` returns one cycle later.
- `y_zero`=1 together with the last `fire`: `done` pulses once the next cycle, then `busy`=0; a `start` during the pass is ignored.
- `rst` asserted during a stalled offer: `rd_valid`, z, `busy` are 0 immediately; no `fire` occurs until a new `start`.

Source files
------------

// File: rtl/l9_pkg.sv
// rtl/l9_pkg.sv - shared layer-9 loop types and constants
package l9_pkg;

   // Channel-loop controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } l9_state_e;

   // Default layer-9 geometry
   localparam int L9_Z_MAX      = 8;
   localparam int L9_ROW_STRIDE = 16;

   // Encoding of the u mode input
   localparam logic [2:0] L9_U_PAUSE   = 3'd0;
   localparam logic [2:0] L9_U_STRIDE2 = 3'd1;

endpackage

// File: rtl/l9_addr_calc.sv
// rtl/l9_addr_calc.sv - combinational BASE + y*ROW_STRIDE + z address, truncated to ADDR_W
module l9_addr_calc #(
   parameter int ADDR_W     = 12,
   parameter int Y_W        = 4,
   parameter int Z_W        = 3,
   parameter int ROW_STRIDE = 16,
   parameter int BASE       = 0
) (
   input  logic [Y_W-1:0]    y,
   input  logic [Z_W-1:0]    z,
   output logic [ADDR_W-1:0] addr
);

   // Arithmetic modulo 2^ADDR_W gives the same low bits as a full-width sum truncated afterwards
   always_comb begin
      addr = ADDR_W'(BASE) + (ADDR_W'(y) * ADDR_W'(ROW_STRIDE)) + ADDR_W'(z);
   end

endmodule

// File: rtl/z_count_addr_l9.sv
// rtl/z_count_addr_l9.sv - layer-9 channel counter and read-address generator; define Z_COUNT_L9_PERF_EN to add stall_cnt
module z_count_addr_l9
   import l9_pkg::*;
#(
   parameter int Z_MAX      = L9_Z_MAX,
   parameter int ROW_STRIDE = L9_ROW_STRIDE,
   parameter int BASE       = 0,
   parameter int ADDR_W     = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [2:0]               u,
   input  logic                     temp_counter,
   input  logic                     temp_zero,
   input  logic [3:0]               y,
   input  logic                     y_zero,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [ADDR_W-1:0]        rd_addr,
   output logic [$clog2(Z_MAX)-1:0] z,
   output logic                     z_zero,
   output logic                     busy,
`ifdef Z_COUNT_L9_PERF_EN
   output logic [15:0]              stall_cnt,
`endif
   output logic                     done
);

   localparam int ZW = $clog2(Z_MAX);
   localparam logic [ZW-1:0] THR_S2 = ZW'(Z_MAX - 2);
   localparam logic [ZW-1:0] THR_S1 = ZW'(Z_MAX - 1);

   l9_state_e     state_q, state_d;
   logic [ZW-1:0] z_q, z_d;
   logic          rd_valid_q, rd_valid_d;

   logic          stride2;
   logic          pause;
   logic          fire;
   logic          at_wrap;
   logic [ZW-1:0] step;
   logic [ZW-1:0] thresh;

   // Mode decode: step size and wrap threshold follow the current u, so a mode change lands on the next fire
   always_comb begin
      stride2 = (u == L9_U_STRIDE2);
      pause   = (temp_counter && !temp_zero) || (u == L9_U_PAUSE);
      fire    = rd_valid_q && rd_ready;
      step    = stride2 ? ZW'(2) : ZW'(1);
      thresh  = stride2 ? THR_S2 : THR_S1;
      at_wrap = (z_q >= thresh);
   end

   // Next state, counter and offer; an offer once raised is only withdrawn by its own fire
   always_comb begin
      state_d    = state_q;
      z_d        = z_q;
      rd_valid_d = rd_valid_q;
      z_zero     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RUN;
               z_d        = '0;
               rd_valid_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (fire) begin
               z_zero = at_wrap;
               z_d    = at_wrap ? '0 : z_q + step;
            end
            if (z_zero && y_zero) begin
               state_d    = ST_DONE;
               rd_valid_d = 1'b0;
            end else if (pause && (!rd_valid_q || fire)) begin
               state_d    = ST_HOLD;
               rd_valid_d = 1'b0;
            end else begin
               rd_valid_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!pause) begin
               state_d    = ST_RUN;
               rd_valid_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d    = ST_IDLE;
            z_d        = '0;
            rd_valid_d = 1'b0;
         end
         default: begin
            state_d    = ST_IDLE;
            z_d        = '0;
            rd_valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset drops any pending offer immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         z_q        <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         z_q        <= z_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign z        = z_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

   l9_addr_calc #(
      .ADDR_W     (ADDR_W),
      .Y_W        (4),
      .Z_W        (ZW),
      .ROW_STRIDE (ROW_STRIDE),
      .BASE       (BASE)
   ) u_addr_calc (
      .y    (y),
      .z    (z_q),
      .addr (rd_addr)
   );

`ifdef Z_COUNT_L9_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where an offer waits on the memory; a new pass starts from zero
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == ST_IDLE) && start) begin
         stall_cnt_d = '0;
      end else if (rd_valid_q && !rd_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Stall counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_z_count_addr_l9.sv
// tb/tb_z_count_addr_l9.sv - scoreboard bench for z_count_addr_l9
module tb_z_count_addr_l9;

   typedef struct {
      logic [11:0] addr;
      logic [2:0]  z;
      logic        zz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  u;
   logic        temp_counter;
   logic        temp_zero;
   logic [3:0]  y;
   logic        y_zero;
   logic        rd_ready;
   logic        rd_valid;
   logic [11:0] rd_addr;
   logic [2:0]  z;
   logic        z_zero;
   logic        busy;
   logic        done;
`ifdef Z_COUNT_L9_PERF_EN
   logic [15:0] stall_cnt;
`endif

   logic        rst_m, start_m, ready_m, tc_m, tz_m;
   logic [2:0]  u_m;
   logic [3:0]  y_m;
   logic [3:0]  last_row;
   logic        done_due;
   int          n_fire;
   int          n_cmp;
   int          n_bad;
   int          f0;
   exp_t        exp_q[$];

   always #5 clk = ~clk;

   z_count_addr_l9 dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .u            (u),
      .temp_counter (temp_counter),
      .temp_zero    (temp_zero),
      .y            (y),
      .y_zero       (y_zero),
      .rd_ready     (rd_ready),
      .rd_valid     (rd_valid),
      .rd_addr      (rd_addr),
      .z            (z),
      .z_zero       (z_zero),
      .busy         (busy),
`ifdef Z_COUNT_L9_PERF_EN
      .stall_cnt    (stall_cnt),
`endif
      .done         (done)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_pass(input int rows, input int uu);
      exp_t e;
      for (int r = 0; r < rows; r++) begin
         if (uu == 1) begin
            for (int zz = 0; zz < 8; zz += 2) begin
               e.addr = 12'(r * 16 + zz); e.z = 3'(zz); e.zz = (zz == 6);
               exp_q.push_back(e);
            end
         end else begin
            for (int zz = 0; zz < 8; zz++) begin
               e.addr = 12'(r * 16 + zz); e.z = 3'(zz); e.zz = (zz == 7);
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      rst          = rst_m;
      start        = start_m;
      rd_ready     = ready_m;
      u            = u_m;
      temp_counter = tc_m;
      temp_zero    = tz_m;
      y            = y_m;
      y_zero       = (y_m == last_row);
      #1;
      chk_eq("done", 32'(done), 32'(done_due));
      done_due = 1'b0;
      if (rd_valid && rd_ready) begin
         n_fire++;
         chk_eq("fire_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_eq("rd_addr", 32'(rd_addr), 32'(e.addr));
            chk_eq("z", 32'(z), 32'(e.z));
            chk_eq("z_zero", 32'(z_zero), 32'(e.zz));
            if (e.zz) begin
               if (y_zero) begin
                  done_due = 1'b1;
                  y_m      = 4'd0;
               end else begin
                  y_m = y_m + 4'd1;
               end
            end
         end
      end else begin
         chk_eq("z_zero_no_fire", 32'(z_zero), 32'd0);
      end
   endtask

   task automatic run_pass(input int max);
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while ((busy || (exp_q.size() != 0)) && (k < max));
      chk_eq("pass_end_busy", 32'(busy), 32'd0);
      chk_eq("pass_queue_empty", 32'(exp_q.size()), 32'd0);
      chk_eq("pass_end_z", 32'(z), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_bad = 0; n_fire = 0; done_due = 1'b0;
      rst = 1'b1; start = 1'b0; u = 3'd2; temp_counter = 1'b0; temp_zero = 1'b0;
      y = 4'd0; y_zero = 1'b0; rd_ready = 1'b0;
      rst_m = 1'b1; start_m = 1'b0; ready_m = 1'b0; u_m = 3'd2; tc_m = 1'b0; tz_m = 1'b0;
      y_m = 4'd3; last_row = 4'd0;

      // reset values
      repeat (2) tick();
      chk_eq("rst_valid", 32'(rd_valid), 32'd0);
      chk_eq("rst_z", 32'(z), 32'd0);
      chk_eq("rst_busy", 32'(busy), 32'd0);
      chk_eq("rst_addr", 32'(rd_addr), 32'd48);
      rst_m = 1'b0;
      tick();

      // stride-1, two rows, ready always high
      y_m = 4'd0; last_row = 4'd1; ready_m = 1'b1; u_m = 3'd2;
      push_pass(2, 2);
      f0 = n_fire;
      start_m = 1'b1; tick();
      chk_eq("valid_cycle0", 32'(rd_valid), 32'd0);
      start_m = 1'b0; tick();
      chk_eq("valid_cycle1", 32'(rd_valid), 32'd1);
      chk_eq("busy_cycle1", 32'(busy), 32'd1);
      run_pass(100);
      chk_eq("s1_fires", 32'(n_fire - f0), 32'd16);

      // stride-2, two rows, with a start mid-pass that must be ignored
      last_row = 4'd1; u_m = 3'd1;
      push_pass(2, 1);
      f0 = n_fire;
      start_m = 1'b1; tick(); start_m = 1'b0;
      repeat (3) tick();
      start_m = 1'b1; tick(); start_m = 1'b0;
      run_pass(100);
      chk_eq("s2_fires", 32'(n_fire - f0), 32'd8);

      // memory stall of five cycles on the first offer
      last_row = 4'd0; u_m = 3'd2; ready_m = 1'b0;
      push_pass(1, 2);
      start_m = 1'b1; tick(); start_m = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_eq("stall_valid", 32'(rd_valid), 32'd1);
         chk_eq("stall_addr", 32'(rd_addr), 32'd0);
         chk_eq("stall_z", 32'(z), 32'd0);
      end
      ready_m = 1'b1; tick();
`ifdef Z_COUNT_L9_PERF_EN
      chk_eq("stall_cnt", 32'(stall_cnt), 32'd5);
`endif
      run_pass(100);

      // temp-loop hold mid-row: pending fire completes, then HOLD
      push_pass(1, 2);
      start_m = 1'b1; tick(); start_m = 1'b0;
      repeat (3) tick();
      tc_m = 1'b1; tz_m = 1'b0; tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_eq("hold_valid", 32'(rd_valid), 32'd0);
         chk_eq("hold_z", 32'(z), 32'd4);
         chk_eq("hold_busy", 32'(busy), 32'd1);
      end
      tc_m = 1'b0; tick();
      chk_eq("release_valid_same", 32'(rd_valid), 32'd0);
      tick();
      chk_eq("release_valid_next", 32'(rd_valid), 32'd1);
      run_pass(100);

      // reset during a stalled offer
      push_pass(1, 2);
      start_m = 1'b1; tick(); start_m = 1'b0;
      repeat (3) tick();
      ready_m = 1'b0; tick();
      chk_eq("pre_rst_valid", 32'(rd_valid), 32'd1);
      chk_eq("pre_rst_z", 32'(z), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk_eq("async_rst_valid", 32'(rd_valid), 32'd0);
      chk_eq("async_rst_z", 32'(z), 32'd0);
      chk_eq("async_rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      y_m = 4'd0; rst_m = 1'b1; ready_m = 1'b1; tick();
      rst_m = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_eq("post_rst_no_offer", 32'(rd_valid), 32'd0);
      end
      push_pass(1, 2);
      start_m = 1'b1; tick(); start_m = 1'b0;
      run_pass(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
